sysbus_arbiter: RTL and testbench

- Shares the single system/main bus among NUM_REQ masters: instruction fetch, data load, and store_data write-back.
- Arbitrates the masters' abtr_reqcyc requests round-robin and issues a one-hot registered grant.
- Holds ownership while the owner's bus_busy is high.
- Muxes the owner's request-side bus signals onto the main bus and steers the response side back to the owner only.

---
 rtl/sysbus_pkg.sv | 25 ++
 rtl/sysbus_arbiter_rr_picker.sv | 32 +++
 rtl/sysbus_arbiter.sv | 128 ++++++++++++
 tb/tb_sysbus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared types and constants for the system bus arbiter slice: FSM state
// encoding, bus tag fields and default bus widths.
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_BUS_DATA_WIDTH = 64;
    localparam int DEF_BUS_TAG_WIDTH  = 13;

    localparam logic       SYSBUS_READ   = 1'b0;
    localparam logic       SYSBUS_WRITE  = 1'b1;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    // Tag layout: direction in bit 12, address space in bits 11:8.
    function automatic logic [DEF_BUS_TAG_WIDTH-1:0] sysbus_tag(input logic rw,
                                                                input logic [3:0] space);
        return {rw, space, 8'h00};
    endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping around, returned as one-hot, index and an any-valid flag.
module rr_picker #(
    parameter int  N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int c;
        // NOTE: every output gets a default before the search so no path can infer a latch.
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        c      = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any       = 1'b1;
                onehot[c] = 1'b1;
                idx       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner of the shared main bus: registered one-hot grant, ownership
// held on bus_busy, request side muxed from the owner, response steered to it.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int  NUM_REQ        = 3,
    parameter int  BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int  BUS_TAG_WIDTH  = DEF_BUS_TAG_WIDTH,
    parameter int  GRANT_TIMEOUT  = 8,
    localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                m_reqcyc_arb,
    input  logic [NUM_REQ-1:0]                m_busy,
    output logic [NUM_REQ-1:0]                m_grant,
    input  logic [NUM_REQ-1:0]                m_bus_reqcyc,
    input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] m_bus_req,
    input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic [NUM_REQ-1:0]                m_bus_respack,
    output logic [NUM_REQ-1:0]                m_bus_reqack,
    output logic [NUM_REQ-1:0]                m_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]         m_bus_resp,
    output logic                              bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    output logic                              bus_respack,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
    output logic [IDX_W-1:0]                  owner,
    output logic                              owner_valid
);

    localparam int CNT_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;

    arb_state_t         state, state_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               busy_own;
    logic               req_own;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .req    (m_reqcyc_arb),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner_q <= '0;
            grant_q <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= (state == GRANT) ? tmo_cnt + 1'b1 : '0;
            if (state == IDLE && pick_any) begin
                owner_q <= pick_idx;
                grant_q <= pick_onehot;
            end
            if (state == RELEASE) begin
                rr_ptr <= (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            end
        end
    end

    // Busy is checked before revocation so a late busy still wins over timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_any) state_next = GRANT;
            GRANT: begin
                if (busy_own)
                    state_next = OWNED;
                else if (!req_own || tmo_cnt == CNT_W'(GRANT_TIMEOUT - 1))
                    state_next = RELEASE;
            end
            OWNED:   if (!busy_own) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign owner_valid = (state == GRANT) || (state == OWNED);
    assign m_grant     = owner_valid ? grant_q : '0;
    assign owner       = owner_q;
    assign m_bus_resp  = bus_resp;

    always_comb begin
        bus_reqcyc    = 1'b0;
        bus_req       = '0;
        bus_reqtag    = '0;
        bus_respack   = 1'b0;
        m_bus_reqack  = '0;
        m_bus_respcyc = '0;
        busy_own      = 1'b0;
        req_own       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                busy_own = m_busy[i];
                req_own  = m_reqcyc_arb[i];
                if (owner_valid) begin
                    bus_reqcyc       = m_bus_reqcyc[i];
                    bus_req          = m_bus_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    bus_reqtag       = m_bus_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                    bus_respack      = m_bus_respack[i];
                    m_bus_reqack[i]  = bus_reqack;
                    m_bus_respcyc[i] = bus_respcyc;
                end
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(m_grant));
    a_busy_owner:   assert property (@(posedge clk) disable iff (reset) (m_busy & ~m_grant) == '0);

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed and randomized checks of sysbus_arbiter against a transaction-level
// reference model of ownership (owner, dead-time, round-robin pointer).
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    localparam int N  = 3;
    localparam int W  = 64;
    localparam int T  = 13;
    localparam int TO = 8;

    logic             clk;
    logic             reset;
    logic [N-1:0]     m_reqcyc_arb, m_busy, m_grant;
    logic [N-1:0]     m_bus_reqcyc, m_bus_respack, m_bus_reqack, m_bus_respcyc;
    logic [N*W-1:0]   m_bus_req;
    logic [N*T-1:0]   m_bus_reqtag;
    logic [W-1:0]     m_bus_resp, bus_req, bus_resp;
    logic             bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
    logic [T-1:0]     bus_reqtag;
    logic [1:0]       owner;
    logic             owner_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 none), busy seen, grant age, dead cycles, next pointer.
    int mo = -1;
    bit mb = 1'b0;
    int mage = 0;
    int mgap = 0;
    int mnext = 0;

    sysbus_arbiter #(.NUM_REQ(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T), .GRANT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_reqcyc_arb(m_reqcyc_arb), .m_busy(m_busy), .m_grant(m_grant),
        .m_bus_reqcyc(m_bus_reqcyc), .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
        .m_bus_respack(m_bus_respack), .m_bus_reqack(m_bus_reqack), .m_bus_respcyc(m_bus_respcyc),
        .m_bus_resp(m_bus_resp), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .owner(owner), .owner_valid(owner_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_release();
        mnext = (mo + 1) % N;
        mo    = -1;
        mb    = 1'b0;
        mgap  = 1;
    endtask

    // Ownership rules applied once per rising edge to the inputs the edge sees.
    task automatic model_edge();
        if (reset) begin
            mo = -1; mb = 1'b0; mage = 0; mgap = 0; mnext = 0;
        end else if (mo >= 0) begin
            if (mb) begin
                if (!m_busy[mo]) model_release();
            end else if (m_busy[mo]) begin
                mb = 1'b1;
            end else if (!m_reqcyc_arb[mo] || mage == TO - 1) begin
                model_release();
            end else begin
                mage++;
            end
        end else if (mgap > 0) begin
            mgap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mnext + k) % N;
                if (m_reqcyc_arb[c]) begin
                    mo = c; mb = 1'b0; mage = 0;
                    break;
                end
            end
        end
    endtask

    task automatic check_cycle(input string tag);
        logic [N-1:0] e_grant, e_rack, e_rcyc;
        logic [W-1:0] e_req;
        logic [T-1:0] e_tag;
        logic         e_cyc, e_pack;
        e_grant = '0; e_rack = '0; e_rcyc = '0;
        e_req = '0; e_tag = '0; e_cyc = 1'b0; e_pack = 1'b0;
        if (mo >= 0) begin
            e_grant[mo] = 1'b1;
            e_rack[mo]  = bus_reqack;
            e_rcyc[mo]  = bus_respcyc;
            e_req       = m_bus_req[mo*W +: W];
            e_tag       = m_bus_reqtag[mo*T +: T];
            e_cyc       = m_bus_reqcyc[mo];
            e_pack      = m_bus_respack[mo];
            check({tag, ".owner"}, owner, mo);
        end
        check({tag, ".grant"}, m_grant, e_grant);
        check({tag, ".owner_valid"}, owner_valid, mo >= 0);
        check({tag, ".bus_reqcyc"}, bus_reqcyc, e_cyc);
        check({tag, ".bus_req"}, bus_req, e_req);
        check({tag, ".bus_reqtag"}, bus_reqtag, e_tag);
        check({tag, ".bus_respack"}, bus_respack, e_pack);
        check({tag, ".m_bus_reqack"}, m_bus_reqack, e_rack);
        check({tag, ".m_bus_respcyc"}, m_bus_respcyc, e_rcyc);
        check({tag, ".m_bus_resp"}, m_bus_resp, bus_resp);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle(tag);
    endtask

    task automatic clear_inputs();
        m_reqcyc_arb = '0; m_busy = '0; m_bus_reqcyc = '0; m_bus_respack = '0;
        m_bus_req = '0; m_bus_reqtag = '0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step("reset");
        step("reset");
        reset = 1'b0;
    endtask

    task automatic randomize_bus();
        for (int i = 0; i < N; i++) begin
            m_bus_req[i*W +: W]    = {$urandom, $urandom};
            m_bus_reqtag[i*T +: T] = T'($urandom);
        end
        m_bus_reqcyc  = N'($urandom);
        m_bus_respack = N'($urandom);
        bus_reqack    = 1'($urandom);
        bus_respcyc   = 1'($urandom);
        bus_resp      = {$urandom, $urandom};
    endtask

    initial begin
        logic [W-1:0]   d;
        logic [N-1:0]   prev_grant;
        logic [N-1:0]   order [6];
        int             ngr, held, prev_own, cnt;

        reset = 1'b1;
        clear_inputs();
        @(negedge clk);

        // Reset state
        do_reset();
        check("reset_grant", m_grant, 3'b000);
        check("reset_owner", owner, 2'd0);
        check("reset_owner_valid", owner_valid, 1'b0);
        check("reset_bus_reqcyc", bus_reqcyc, 1'b0);

        // Single master 2, held busy for 10 cycles with changing data
        m_reqcyc_arb = 3'b100;
        step("t1");
        check("t1_grant", m_grant, 3'b100);
        m_busy = 3'b100;
        m_bus_reqcyc = 3'b100;
        for (int k = 0; k < 10; k++) begin
            d = {$urandom, $urandom};
            m_bus_req[2*W +: W] = d;
            step("t1");
            check("t1_bus_req", bus_req, d);
        end
        m_busy = '0; m_bus_reqcyc = '0; m_reqcyc_arb = '0;
        step("t1");
        check("t1_drop", m_grant, 3'b000);
        step("t1");
        check("t1_dead", m_grant, 3'b000);

        // Fairness: all request continuously, each owner holds busy 3 cycles
        do_reset();
        m_reqcyc_arb = 3'b111;
        ngr = 0; held = 0; prev_own = -1; prev_grant = '0;
        for (int cyc = 0; cyc < 80 && ngr < 6; cyc++) begin
            m_busy = '0;
            if (mo >= 0) begin
                if (mo != prev_own) begin held = 0; prev_own = mo; end
                if (held < 3) begin m_busy[mo] = 1'b1; held++; end
            end
            step("t2");
            check("t2_no_back_to_back",
                  (prev_grant != '0 && m_grant != '0 && m_grant != prev_grant), 1'b0);
            if (prev_grant == '0 && m_grant != '0) begin
                order[ngr] = m_grant;
                ngr++;
            end
            prev_grant = m_grant;
        end
        check("t2_grant_count", ngr, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ngr) check("t2_order", order[i], 3'b001 << (i % 3));
        end
        m_busy = '0; m_reqcyc_arb = '0;
        step("t2");

        // Timeout: master 1 never raises busy, master 2 waits
        do_reset();
        m_reqcyc_arb = 3'b110;
        step("t3");
        check("t3_first_grant", m_grant, 3'b010);
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            step("t3");
            if (m_grant == 3'b010) cnt++;
            else break;
        end
        check("t3_grant_cycles", cnt, TO);
        for (int k = 0; k < 6; k++) begin
            if (m_grant == 3'b100) break;
            step("t3");
        end
        check("t3_next_owner", m_grant, 3'b100);
        m_reqcyc_arb = '0;
        step("t3");

        // Response steering to master 0
        do_reset();
        m_reqcyc_arb = 3'b001;
        step("t4");
        m_busy = 3'b001;
        bus_respcyc = 1'b1;
        bus_reqack = 1'b1;
        bus_resp = 64'hDEAD_BEEF;
        step("t4");
        check("t4_respcyc", m_bus_respcyc, 3'b001);
        check("t4_resp", m_bus_resp, 64'hDEAD_BEEF);
        check("t4_reqack", m_bus_reqack, 3'b001);
        m_busy = '0; m_reqcyc_arb = '0; bus_respcyc = 1'b0; bus_reqack = 1'b0;
        step("t4");

        // Reset during ownership by master 2
        do_reset();
        m_reqcyc_arb = 3'b100;
        step("t5");
        m_busy = 3'b100;
        m_bus_reqcyc = 3'b100;
        bus_respcyc = 1'b1;
        step("t5");
        step("t5");
        check("t5_owned", m_grant, 3'b100);
        reset = 1'b1;
        m_busy = '0;
        m_reqcyc_arb = 3'b101;
        step("t5");
        check("t5_reset_grant", m_grant, 3'b000);
        check("t5_reset_valid", owner_valid, 1'b0);
        check("t5_reset_owner", owner, 2'd0);
        check("t5_reset_respcyc", m_bus_respcyc, 3'b000);
        check("t5_reset_reqcyc", bus_reqcyc, 1'b0);
        reset = 1'b0;
        step("t5");
        check("t5_after_reset", m_grant, 3'b001);
        m_reqcyc_arb = '0; bus_respcyc = 1'b0; m_bus_reqcyc = '0;
        step("t5");

        // Store write-back: 9 beats with the write/memory tag, then request end
        do_reset();
        m_reqcyc_arb = 3'b100;
        m_bus_reqtag[2*T +: T] = sysbus_tag(SYSBUS_WRITE, SYSBUS_MEMORY);
        step("t6");
        m_busy = 3'b100;
        for (int k = 0; k < 9; k++) begin
            m_bus_reqcyc = 3'b100;
            m_bus_req[2*W +: W] = {$urandom, $urandom};
            step("t6");
            check("t6_tag", bus_reqtag, 13'h1100);
            check("t6_reqcyc", bus_reqcyc, 1'b1);
        end
        m_bus_reqcyc = '0;
        step("t6");
        check("t6_hold_after_end", m_grant, 3'b100);
        m_busy = '0; m_reqcyc_arb = '0;
        step("t6");
        check("t6_release", m_grant, 3'b000);

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) m_reqcyc_arb[i] = ($urandom_range(0, 3) != 0);
            m_busy = '0;
            if (mo >= 0) begin
                if (mb) m_busy[mo] = ($urandom_range(0, 3) != 0);
                else    m_busy[mo] = ($urandom_range(0, 5) == 0);
            end
            randomize_bus();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
